// File: rtl/alu_cmd_driver.sv
// Initiator for the registered 4-bit ALU: takes one request, waits out the ALU latency,
// returns the tagged result. Define ALU_CHECK_EN to add the golden-model self-check.
module alu_cmd_driver #(
   parameter int ALU_LAT = 1,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_opcode,
   input  logic [3:0]       req_a,
   input  logic [3:0]       req_b,
   output logic [1:0]       alu_opcode,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   input  logic [4:0]       alu_c,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [4:0]       rsp_c,
   output logic [1:0]       rsp_opcode,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   state_t           state_q, state_d;
   logic [2:0]       wait_q, wait_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic [3:0]       alu_a_q, alu_a_d;
   logic [3:0]       alu_b_q, alu_b_d;
   logic [4:0]       rsp_c_q, rsp_c_d;
   logic [1:0]       rsp_op_q, rsp_op_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      tag_d     = tag_q;
      alu_op_d  = alu_op_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      rsp_c_d   = rsp_c_q;
      rsp_op_d  = rsp_op_q;
      rsp_tag_d = rsp_tag_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               alu_op_d = req_opcode;
               alu_a_d  = req_a;
               alu_b_d  = req_b;
               rsp_op_d = req_opcode;
               wait_d   = 3'(ALU_LAT);
               state_d  = EXEC;
            end
         end
         EXEC: begin
            // Dwell exactly ALU_LAT edges so alu_c is settled on entry to CAPT.
            wait_d = wait_q - 3'd1;
            if (wait_q == 3'd1) begin
               state_d = CAPT;
            end
         end
         CAPT: begin
            rsp_c_d   = alu_c;
            rsp_tag_d = tag_q;
            state_d   = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               tag_d   = tag_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         tag_q     <= '0;
         alu_op_q  <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         rsp_c_q   <= '0;
         rsp_op_q  <= '0;
         rsp_tag_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         tag_q     <= tag_d;
         alu_op_q  <= alu_op_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         rsp_c_q   <= rsp_c_d;
         rsp_op_q  <= rsp_op_d;
         rsp_tag_q <= rsp_tag_d;
      end
   end

   // Gated with reset_n so every output reads 0 while reset is asserted.
   assign req_ready  = reset_n && (state_q == IDLE);
   assign rsp_valid  = (state_q == RESP);
   assign alu_opcode = alu_op_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp_c      = rsp_c_q;
   assign rsp_opcode = rsp_op_q;
   assign rsp_tag    = rsp_tag_q;

`ifdef ALU_CHECK_EN
   logic [4:0] exp_c;
   logic       rsp_err_q, rsp_err_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      case (alu_op_q)
         2'b00:   exp_c = {alu_a_q[3], alu_a_q} + {alu_b_q[3], alu_b_q};
         2'b01:   exp_c = {alu_a_q[3], alu_a_q} - {alu_b_q[3], alu_b_q};
         2'b10:   exp_c = ~{alu_a_q[3], alu_a_q};
         default: exp_c = {4'b0000, |alu_b_q};
      endcase
   end

   always_comb begin
      rsp_err_d = rsp_err_q;
      err_cnt_d = err_cnt_q;
      if (state_q == CAPT) begin
         rsp_err_d = (alu_c != exp_c);
      end
      if ((state_q == RESP) && rsp_ready && rsp_err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_err_q <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         rsp_err_q <= rsp_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rsp_err = rsp_err_q;
   assign err_cnt = err_cnt_q;
`else
   assign rsp_err = 1'b0;
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural registered ALU (one edge latency).
module tb_alu_cmd_driver;

   localparam int LAT = 1;
`ifdef ALU_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_opcode = '0;
   logic [3:0] req_a = '0;
   logic [3:0] req_b = '0;
   logic [1:0] alu_opcode;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [4:0] alu_c = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [4:0] rsp_c;
   logic [1:0] rsp_opcode;
   logic [3:0] rsp_tag;
   logic       rsp_err;
   logic [7:0] err_cnt;

   logic       corrupt = 1'b0;
   logic [3:0] exp_tag = '0;
   logic [7:0] exp_err_cnt = '0;
   int         n_tests = 0;
   int         n_fail = 0;

   alu_cmd_driver #(.ALU_LAT(LAT), .TAG_W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
      .rsp_opcode(rsp_opcode), .rsp_tag(rsp_tag),
      .rsp_err(rsp_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Registered ALU; corrupt forces a wrong result of 0.
   always @(posedge clk) begin
      if (corrupt) alu_c <= 5'd0;
      else begin
         case (alu_opcode)
            2'b00:   alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
            2'b01:   alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
            2'b10:   alu_c <= ~{alu_a[3], alu_a};
            default: alu_c <= {4'b0000, |alu_b};
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #3;
      exp_tag = '0;
      exp_err_cnt = '0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [4:0] exp_c,
                         input logic exp_err, input int stall);
      int edges;
      edges = 0;
      while (!req_ready && edges < 20) begin
         @(posedge clk); #1; edges++;
      end
      check_eq({name, "_req_ready_idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
      @(posedge clk); #1;
      // Keep a garbage request asserted while busy; it must be ignored.
      req_opcode = ~op; req_a = ~a; req_b = ~b;
      edges = 1;
      check_eq({name, "_alu_op"}, 32'(alu_opcode), 32'(op));
      check_eq({name, "_alu_a"}, 32'(alu_a), 32'(a));
      check_eq({name, "_alu_b"}, 32'(alu_b), 32'(b));
      while (!rsp_valid && edges < 12) begin
         check_eq({name, "_req_ready_busy"}, 32'(req_ready), 32'd0);
         @(posedge clk); #1; edges++;
      end
      check_eq({name, "_latency"}, 32'(edges), 32'(LAT + 2));
      check_eq({name, "_rsp_c"}, 32'(rsp_c), 32'(exp_c));
      check_eq({name, "_rsp_tag"}, 32'(rsp_tag), 32'(exp_tag));
      check_eq({name, "_rsp_op"}, 32'(rsp_opcode), 32'(op));
      check_eq({name, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
      check_eq({name, "_req_ready_resp"}, 32'(req_ready), 32'd0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check_eq({name, "_stall_valid"}, 32'(rsp_valid), 32'd1);
         check_eq({name, "_stall_c"}, 32'(rsp_c), 32'(exp_c));
         check_eq({name, "_stall_tag"}, 32'(rsp_tag), 32'(exp_tag));
         check_eq({name, "_stall_err"}, 32'(rsp_err), 32'(exp_err));
         check_eq({name, "_stall_ready"}, 32'(req_ready), 32'd0);
         check_eq({name, "_stall_alu_a"}, 32'(alu_a), 32'(a));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (exp_err && exp_err_cnt != 8'hFF) exp_err_cnt++;
      exp_tag++;
      check_eq({name, "_rsp_valid_done"}, 32'(rsp_valid), 32'd0);
      check_eq({name, "_req_ready_done"}, 32'(req_ready), 32'd1);
      check_eq({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
      $display("[TB] %s op=%0d a=%0h b=%0h rsp_c=%0h tag=%0d err=%0d", name, op, a, b,
               rsp_c, exp_tag - 4'd1, exp_err);
   endtask

   initial begin
      #2;
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_alu_a", 32'(alu_a), 32'd0);
      check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
      do_reset();
      #1;
      check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);

      run_op("add77", 2'b00, 4'd7, 4'd7, 5'b01110, 1'b0, 0);

      do_reset();
      run_op("sub_m8_7", 2'b01, 4'b1000, 4'd7, 5'b10001, 1'b0, 0);
      run_op("notA_5", 2'b10, 4'b0101, 4'd0, 5'b11010, 1'b0, 0);

      run_op("ror_b0", 2'b11, 4'd9, 4'd0, 5'd0, 1'b0, 0);
      run_op("ror_b8", 2'b11, 4'd0, 4'b1000, 5'd1, 1'b0, 0);

      run_op("bp_sub", 2'b01, 4'd3, 4'd5, 5'b11110, 1'b0, 5);

      do_reset();
      for (int i = 0; i < 17; i++) begin
         if (i % 2 == 0) run_op("wrap_add", 2'b00, 4'd1, 4'd2, 5'd3, 1'b0, 0);
         else            run_op("wrap_not", 2'b10, 4'd0, 4'd0, 5'b11111, 1'b0, 0);
      end
      check_eq("wrap_tag_next", 32'(exp_tag), 32'd1);

      // Abort an operation in EXEC with an asynchronous reset.
      @(negedge clk);
      req_valid = 1'b1; req_opcode = 2'b00; req_a = 4'd6; req_b = 4'd1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("abort_alu_a_pre", 32'(alu_a), 32'd6);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("abort_alu_a", 32'(alu_a), 32'd0);
      check_eq("abort_alu_b", 32'(alu_b), 32'd0);
      check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("abort_rsp_tag", 32'(rsp_tag), 32'd0);
      @(posedge clk); #1;
      check_eq("abort_rsp_valid_hold", 32'(rsp_valid), 32'd0);
      exp_tag = '0;
      exp_err_cnt = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
      run_op("after_abort", 2'b00, 4'd2, 4'b1111, 5'd1, 1'b0, 0);

      corrupt = 1'b1;
      run_op("bad_add32", 2'b00, 4'd3, 4'd2, 5'd0, CHK_EN, 0);
      corrupt = 1'b0;
      run_op("good_add32", 2'b00, 4'd3, 4'd2, 5'd5, 1'b0, 2);
      check_eq("final_err_cnt", 32'(err_cnt), CHK_EN ? 32'd1 : 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the 4-bit ALU operation interface.
- Accepts one operation request from an upstream agent (test sequencer or control logic) over a valid/ready handshake, and drives opcode and operands into the registered ALU.
- Waits out the ALU's registered-output latency, captures the 5-bit result, and returns it on a valid/ready response channel tagged with a sequence number.

Parameters:
- ALU_LAT, 1: clock edges between ALU inputs changing and the ALU registered output reflecting them; legal range 1-7.
- TAG_W, 4: width of the wrapping transaction tag.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_opcode  in  2  00 add, 01 sub, 10 not A, 11 reduction-OR B.
- req_a  in  4  operand A, signed two's complement.
- req_b  in  4  operand B, signed two's complement.
- alu_opcode  out  2  registered opcode to ALU.
- alu_a  out  4  registered operand A to ALU.
- alu_b  out  4  registered operand B to ALU.
- alu_c  in  5  ALU registered result, signed.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  downstream accepts response.
- rsp_c  out  5  captured result.
- rsp_opcode  out  2  opcode of this response.
- rsp_tag  out  TAG_W  sequence number of this response.
- rsp_err  out  1  self-check mismatch; see Optional Feature.
- err_cnt  out  8  saturating mismatch count; see Optional Feature.

Behaviour:
- Reset (reset_n low, asynchronous): FSM to IDLE; all outputs and registers go to 0. This includes alu_*, rsp_*, tag counter, wait counter, and err_cnt. req_ready is 1 in IDLE once reset is released.
- States: IDLE, EXEC, CAPT, RESP.
- IDLE: req_ready=1, rsp_valid=0.
  - On an edge with req_valid=1: register req_opcode/a/b into alu_opcode/a/b and into rsp_opcode; load wait counter with ALU_LAT; go to EXEC.
- EXEC: req_ready=0. Decrement the wait counter each edge; when it reaches 0, go to CAPT.
  - The EXEC dwell is ALU_LAT edges, so alu_c is valid on entry to CAPT.
- CAPT: on the next edge, rsp_c <= alu_c, rsp_tag <= tag counter, then go to RESP.
- RESP: rsp_valid=1. rsp_c, rsp_opcode, rsp_tag and rsp_err are held stable while rsp_ready=0.
  - On an edge with rsp_ready=1: tag counter increments (wraps 2^TAG_W-1 -> 0) and the FSM goes to IDLE.
  - Requests are not accepted in RESP.
- Latency: request accept edge to rsp_valid high is ALU_LAT+2 edges (3 at default). Minimum throughput is one op per ALU_LAT+3 cycles.
- alu_opcode/a/b hold their last value outside EXEC/CAPT; they change only on a request accept edge.
- rsp_c is a raw copy of alu_c; the driver does no arithmetic.
- An asynchronous reset in any state aborts the transaction silently: no response, tag back to 0.
- req_valid is ignored in non-IDLE states; upstream must hold the request until req_ready=1.

Optional Feature:
- Macro: ALU_CHECK_EN.
- Defined: an internal golden model computes the expected 5-bit result from the latched operands.
  - add: sign-extended A+B.
  - sub: sign-extended A-B.
  - not A: bitwise invert of {A[3],A}.
  - reduction-OR: 5'd1 if B!=0, else 0.
  - In CAPT, rsp_err <= (alu_c != expected).
  - err_cnt increments by 1 on each RESP handshake with rsp_err=1, saturating at 255.
- Not defined: rsp_err and err_cnt are constant 0; no model logic is synthesized.

Test Plan:
- Add, A=7 B=7, rsp_ready=1 -> rsp_valid rises 3 edges after accept; rsp_c=5'b01110 (14), rsp_tag=0, rsp_err=0.
- Sub, A=-8 B=7, then not A with A=4'b0101 -> rsp_c=5'b10001 (-15), then rsp_c=5'b11010 (-6); tags 0 then 1.
- Reduction-OR, B=0 then B=4'b1000 -> rsp_c=0 then 1; req_ready=0 throughout EXEC/CAPT/RESP.
- Backpressure: rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready=0; with rsp_ready high, FSM returns to IDLE; 17 back-to-back ops -> rsp_tag wraps 15 -> 0.
- reset_n pulsed low during EXEC -> immediate IDLE, alu_*=0, no rsp_valid; the next op returns rsp_tag=0.
- ALU_CHECK_EN defined, alu_c forced to 5'b00000 for add A=3 B=2 -> rsp_err=1, err_cnt=1; a correct op after it -> rsp_err=0, err_cnt stays 1.
